// File: rtl/incdec_dco.sv
`default_nettype none
// ============================================================================
// Module      : incdec_dco
// Description : Increment/decrement digitally controlled oscillator for the
//               ADPLL loop. Divides clk by DIVIDE_RATIO and turns one-cycle
//               advance/retard requests from the loop filter into whole-cycle
//               period corrections (one correction at most per period).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DIVIDE_RATIO  : nominal clk cycles per output period (even, >= 4)
//   COUNTER_WIDTH : width of the phase counter (must hold DIVIDE_RATIO)
//   PENDING_WIDTH : signed width of the correction backlog
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   i_positive    in   one-cycle request to advance phase by one cycle
//   i_negative    in   one-cycle request to retard phase by one cycle
//   o_out_clock   out  recovered clock, high for DIVIDE_RATIO/2 cycles
//   o_sample      out  one-cycle strobe while the phase is 0 after a wrap
//   o_phase_count out  position within the current period
//   o_pending     out  signed backlog of unapplied corrections
//   o_dropped     out  one-cycle pulse when a request is lost to saturation
// ============================================================================
module incdec_dco #(
    parameter int DIVIDE_RATIO  = 16,
    parameter int COUNTER_WIDTH = 8,
    parameter int PENDING_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_positive,
    input  logic                     i_negative,
    output logic                     o_out_clock,
    output logic                     o_sample,
    output logic [COUNTER_WIDTH-1:0] o_phase_count,
    output logic [PENDING_WIDTH-1:0] o_pending,
    output logic                     o_dropped
);

    // Terminal counts for the three possible period lengths.
    localparam logic [COUNTER_WIDTH-1:0] c_term_nominal = COUNTER_WIDTH'(DIVIDE_RATIO - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_term_advance = COUNTER_WIDTH'(DIVIDE_RATIO - 2);
    localparam logic [COUNTER_WIDTH-1:0] c_term_retard  = COUNTER_WIDTH'(DIVIDE_RATIO);
    localparam logic [COUNTER_WIDTH-1:0] c_half         = COUNTER_WIDTH'(DIVIDE_RATIO / 2);

    // Backlog arithmetic is done two bits wider so the pre-saturation sum
    // (at most +/-(max+2)) can never wrap.
    localparam int c_ext_w       = PENDING_WIDTH + 2;
    localparam int c_max_pending = (1 << (PENDING_WIDTH - 1)) - 1;
    localparam logic signed [c_ext_w-1:0] c_pend_hi = c_ext_w'(c_max_pending);
    localparam logic signed [c_ext_w-1:0] c_pend_lo = -c_pend_hi;

    // Two-bit signed encodings of -1 / 0 / +1.
    localparam logic signed [1:0] c_plus  = 2'sb01;
    localparam logic signed [1:0] c_zero  = 2'sb00;
    localparam logic signed [1:0] c_minus = 2'sb11;

    logic [COUNTER_WIDTH-1:0]        r_phase;
    logic signed [1:0]               r_adj;
    logic signed [PENDING_WIDTH-1:0] r_pending;
    logic                            r_out_clock;
    logic                            r_sample;
    logic                            r_dropped;

    logic [COUNTER_WIDTH-1:0]        w_terminal;
    logic                            w_wrap;
    logic [COUNTER_WIDTH-1:0]        w_phase_next;
    logic signed [1:0]               w_pend_sign;
    logic signed [1:0]               w_delta;
    logic signed [c_ext_w-1:0]       w_pend_ext;
    logic signed [c_ext_w-1:0]       w_dec_ext;
    logic signed [c_ext_w-1:0]       w_delta_ext;
    logic signed [c_ext_w-1:0]       w_pend_sum;
    logic signed [PENDING_WIDTH-1:0] w_pend_next;
    logic                            w_dropped_next;
    logic signed [1:0]               w_adj_next;
    logic                            w_out_next;

    always_comb begin
        w_terminal     = c_term_nominal;
        w_pend_sign    = c_zero;
        w_delta        = c_zero;
        w_pend_next    = r_pending;
        w_dropped_next = 1'b0;

        // Adj = +1 shortens the period, Adj = -1 lengthens it.
        case (r_adj)
            c_plus:  w_terminal = c_term_advance;
            c_minus: w_terminal = c_term_retard;
            default: w_terminal = c_term_nominal;
        endcase

        w_wrap       = (r_phase == w_terminal);
        w_phase_next = w_wrap ? '0 : r_phase + COUNTER_WIDTH'(1);

        if (r_pending > 0) begin
            w_pend_sign = c_plus;
        end else if (r_pending < 0) begin
            w_pend_sign = c_minus;
        end

        // Simultaneous advance and retard requests cancel.
        if (i_positive && !i_negative) begin
            w_delta = c_plus;
        end else if (i_negative && !i_positive) begin
            w_delta = c_minus;
        end

        // On a wrap one unit of backlog is consumed into the new Adj; an
        // event in the wrap cycle itself still lands in the backlog.
        w_pend_ext  = {{2{r_pending[PENDING_WIDTH-1]}}, r_pending};
        w_dec_ext   = w_wrap ? {{PENDING_WIDTH{w_pend_sign[1]}}, w_pend_sign} : '0;
        w_delta_ext = {{PENDING_WIDTH{w_delta[1]}}, w_delta};
        w_pend_sum  = w_pend_ext - w_dec_ext + w_delta_ext;

        if (w_pend_sum > c_pend_hi) begin
            w_pend_next    = c_pend_hi[PENDING_WIDTH-1:0];
            w_dropped_next = (w_delta != c_zero);
        end else if (w_pend_sum < c_pend_lo) begin
            w_pend_next    = c_pend_lo[PENDING_WIDTH-1:0];
            w_dropped_next = (w_delta != c_zero);
        end else begin
            w_pend_next    = w_pend_sum[PENDING_WIDTH-1:0];
        end

        // Adj uses the backlog sign before this cycle's update.
        w_adj_next = w_wrap ? w_pend_sign : r_adj;

        // Registered copy of (phase < half) for the phase being entered, so
        // the high phase is always DIVIDE_RATIO/2 and the low phase stretches.
        w_out_next = (w_phase_next < c_half);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= '0;
            r_adj       <= c_zero;
            r_pending   <= '0;
            r_out_clock <= 1'b1;
            r_sample    <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_phase     <= w_phase_next;
            r_adj       <= w_adj_next;
            r_pending   <= w_pend_next;
            r_out_clock <= w_out_next;
            r_sample    <= w_wrap;
            r_dropped   <= w_dropped_next;
        end
    end

    assign o_phase_count = r_phase;
    assign o_pending     = r_pending;
    assign o_out_clock   = r_out_clock;
    assign o_sample      = r_sample;
    assign o_dropped     = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_incdec_dco.sv
`default_nettype none
// ============================================================================
// Module      : tb_incdec_dco
// Description : Self-checking bench for incdec_dco. Each table record holds
//               an event schedule and the period lengths it must produce;
//               expected periods are queued at stimulus time and popped as
//               the DUT's Sample strobe closes each period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_incdec_dco;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_positive = 1'b0;
    logic       i_negative = 1'b0;
    logic       o_out_clock;
    logic       o_sample;
    logic [7:0] o_phase_count;
    logic [2:0] o_pending;
    logic       o_dropped;

    always #5 clk = ~clk;

    incdec_dco #(
        .DIVIDE_RATIO  (16),
        .COUNTER_WIDTH (8),
        .PENDING_WIDTH (3)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_positive    (i_positive),
        .i_negative    (i_negative),
        .o_out_clock   (o_out_clock),
        .o_sample      (o_sample),
        .o_phase_count (o_phase_count),
        .o_pending     (o_pending),
        .o_dropped     (o_dropped)
    );

    typedef struct {
        string nm;
        int    ev_period;   // period index holding the events (-1: none)
        int    ev_phase;    // phase of the first event cycle
        int    ev_len;      // number of consecutive event cycles
        bit    pos;
        bit    neg;
        int    nper;        // number of periods to check
        int    per[5];      // expected period lengths
        int    pend_after;  // Pending on the cycle after the last event
        int    drops;       // expected number of Dropped pulses
    } vec_t;

    typedef struct {
        int per;
        int high;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    int n_chk = 0;
    int n_err = 0;

    // Bench-side view of the period, derived from Sample strobes.
    int cnt;
    int hi;
    int idx;
    int drops;
    int phase_obs;

    function automatic vec_t mk(string nm, int ep, int eph, int elen, bit p, bit n,
                                int np, int a, int b, int c, int d, int e,
                                int pa, int dr);
        vec_t v;
        v.nm = nm; v.ev_period = ep; v.ev_phase = eph; v.ev_len = elen;
        v.pos = p; v.neg = n; v.nper = np;
        v.per[0] = a; v.per[1] = b; v.per[2] = c; v.per[3] = d; v.per[4] = e;
        v.pend_after = pa; v.drops = dr;
        return v;
    endfunction

    task automatic check(string name, int act, int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int pend();
        return int'($signed(o_pending));
    endfunction

    task automatic check_reset_values(string tag);
        check({tag, "_phase"},   int'(o_phase_count), 0);
        check({tag, "_pending"}, pend(), 0);
        check({tag, "_outclk"},  int'(o_out_clock), 1);
        check({tag, "_sample"},  int'(o_sample), 0);
        check({tag, "_dropped"}, int'(o_dropped), 0);
    endtask

    // One clock: sample on the falling edge, close a period on Sample.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (o_sample) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("period_len", cnt, e.per);
                check("high_len", hi, e.high);
            end
            cnt = 0;
            hi  = 0;
            idx++;
        end
        check("phase_count", int'(o_phase_count), cnt);
        phase_obs = cnt;
        cnt++;
        hi    += int'(o_out_clock);
        drops += int'(o_dropped);
    endtask

    // Hold reset for a cycle, check reset state, release on a falling edge.
    // The release edge counts as phase 0 of period 0.
    task automatic start_run();
        i_positive = 1'b0;
        i_negative = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        check_reset_values("rst");
        rst_n     = 1'b1;
        cnt       = 1;
        hi        = 1;
        idx       = 0;
        drops     = 0;
        phase_obs = 0;
    endtask

    task automatic run_vec(vec_t v);
        int  guard;
        bit  chk;
        bit  in_ev;
        exp_t e;
        start_run();
        for (int i = 0; i < v.nper; i++) begin
            e.per  = v.per[i];
            e.high = 8;
            sb.push_back(e);
        end
        chk   = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 300) begin
            cycle();
            guard++;
            if (chk) begin
                check({v.nm, "_pend_after"}, pend(), v.pend_after);
                chk = 1'b0;
            end
            in_ev = (idx == v.ev_period) && (phase_obs >= v.ev_phase) &&
                    (phase_obs < v.ev_phase + v.ev_len);
            i_positive = in_ev & v.pos;
            i_negative = in_ev & v.neg;
            if (in_ev && phase_obs == v.ev_phase + v.ev_len - 1) chk = 1'b1;
        end
        i_positive = 1'b0;
        i_negative = 1'b0;
        if (sb.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: %0d periods outstanding, expected 0", v.nm, sb.size());
            sb.delete();
        end
        check({v.nm, "_pend_end"}, pend(), 0);
        check({v.nm, "_drops"}, drops, v.drops);
    endtask

    initial begin
        int guard;
        vecs[0] = mk("idle",     -1,  0, 0, 1'b0, 1'b0, 4, 16, 16, 16, 16,  0,  0, 0);
        vecs[1] = mk("pos_at5",   1,  5, 1, 1'b1, 1'b0, 4, 16, 16, 15, 16,  0,  1, 0);
        vecs[2] = mk("neg_at5",   1,  5, 1, 1'b0, 1'b1, 4, 16, 16, 17, 16,  0, -1, 0);
        vecs[3] = mk("both_at5",  1,  5, 1, 1'b1, 1'b1, 4, 16, 16, 16, 16,  0,  0, 0);
        vecs[4] = mk("pos_x5",    0,  2, 5, 1'b1, 1'b0, 5, 16, 15, 15, 15, 16,  3, 2);
        vecs[5] = mk("pos_wrap",  0, 15, 1, 1'b1, 1'b0, 4, 16, 16, 15, 16,  0,  1, 0);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
        end

        // Asynchronous reset mid-period with a backlog of 2.
        start_run();
        guard = 0;
        while (!(idx == 0 && phase_obs == 9) && guard < 40) begin
            cycle();
            guard++;
            i_positive = (idx == 0) && (phase_obs == 2 || phase_obs == 3);
        end
        i_positive = 1'b0;
        check("midrst_reached_phase9", phase_obs, 9);
        check("midrst_pend_before", pend(), 2);
        check("midrst_outclk_before", int'(o_out_clock), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        run_vec(mk("after_rst", -1, 0, 0, 1'b0, 1'b0, 2, 16, 16, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/incdec_dco.md
# incdec_dco

Increment/decrement digitally controlled oscillator for the ADPLL loop. It consumes the one-cycle `Positive`/`Negative` shift pulses produced by the random-walk loop filter and converts them into whole-cycle phase corrections. Each output period of `OutClock` is shortened by one `MainClock` cycle to advance phase, or lengthened by one cycle to retard it. It sits between the loop filter and the phase comparator, and drives the recovered clock and sampling strobe back into the loop.

## Interface
- `DivideRatio`, 16: nominal `MainClock` cycles per `OutClock` period. Must be even and ≥ 4.
- `CounterWidth`, 8: width of `PhaseCount`. Must hold `DivideRatio`.
- `PendingWidth`, 3: signed width of the correction backlog. Saturation limit `MaxPending` = 2^(PendingWidth-1) − 1 (3 at default).

Ports:
- `MainClock` in 1: system clock. All logic is on the rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `Positive` in 1: one-cycle request to advance phase by one cycle.
- `Negative` in 1: one-cycle request to retard phase by one cycle.
- `OutClock` out 1: recovered clock, registered.
- `Sample` out 1: one-cycle strobe on each period wrap, registered.
- `PhaseCount` out CounterWidth: current position within the period.
- `Pending` out PendingWidth: signed backlog of unapplied corrections.
- `Dropped` out 1: one-cycle pulse when a request is lost to saturation.

## Operation
- `PhaseCount` increments every cycle. It wraps to 0 after reaching terminal value `T` = `DivideRatio` − 1 − `Adj`.
- `Adj` ∈ {−1, 0, +1} is latched at each wrap and holds for the whole new period. It is set to sign(`Pending`), using the value before that cycle's update.
  - `Adj` = +1 gives period `DivideRatio` − 1 (advance).
  - `Adj` = −1 gives period `DivideRatio` + 1 (retard).
  - At most one correction is applied per period.
- Event delta each cycle: d = +1 for `Positive` only, −1 for `Negative` only, 0 for both or neither (they cancel).
- `Pending` update:
  - Non-wrap cycle: `Pending` + d.
  - Wrap cycle: `Pending` − sign(`Pending`) + d.
  - The result saturates at ±`MaxPending`.
  - If saturation discards a nonzero d, `Dropped` pulses the following cycle.
- `OutClock` is a register equal to (`PhaseCount` < `DivideRatio`/2). The high phase is always `DivideRatio`/2 cycles; the low phase absorbs the adjustment.
- `Sample` is a register that is 1 exactly in the cycle after a wrap, i.e. while `PhaseCount` = 0 following a wrap.

## Timing
- Reset values, asserted asynchronously:
  - `PhaseCount` = 0, `Pending` = 0, `Adj` = 0.
  - `OutClock` = 1, `Sample` = 0, `Dropped` = 0.
- The first period after reset release is nominal (`DivideRatio` cycles).
- The first `Sample` pulse occurs `DivideRatio` cycles after the first active edge.
- An event that arrives mid-period affects only the next period's length, never the current one. Minimum latency from event to applied correction is 1 wrap.
- An event in the wrap cycle itself is counted into `Pending`, not into the `Adj` just latched.
- `Pending` reflects a non-wrap event on the next edge.
- `nReset` asserted mid-period aborts the period immediately. Any backlog is discarded.
- `PhaseCount` never exceeds `DivideRatio`. The `Adj` = +1 terminal is `DivideRatio` − 2, so no wrap-around ambiguity arises.

## Test plan
- Reset release, no events, default parameters:
  - `OutClock` is 8 cycles high, 8 low, repeating.
  - `Sample` fires every 16 cycles, the first 16 cycles after release.
  - `Pending` stays 0.
- Single `Positive` at `PhaseCount` = 5:
  - `Pending` becomes 1.
  - The current period is 16 cycles, the next 15 (low phase 7), then 16.
  - `Pending` returns to 0 at the wrap.
- Single `Negative` at `PhaseCount` = 5:
  - The next period is 17 cycles (low phase 9), then 16.
  - `Pending` goes −1 → 0.
- `Positive` and `Negative` in the same cycle → `Pending` unchanged, all periods 16.
- Five consecutive `Positive` pulses starting at `PhaseCount` = 2:
  - `Pending` saturates at 3.
  - `Dropped` pulses twice.
  - The next three periods are 15 cycles, then 16.
- `Positive` at `PhaseCount` = 15 (wrap cycle) with `Pending` = 0 → `Adj` = 0 for the new period, `Pending` = 1, and the following period is 15.
- `nReset` pulled low at `PhaseCount` = 9 with `Pending` = 2:
  - All outputs go to their reset values without waiting for a clock edge.
  - After release, the period is 16.
